lrn_window_buffer: RTL and testbench
====================================

LRN_WINDOW_BUFFER -- requirements
Module: lrn_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one global buffer (GLB) data word.
REQ-002 SHALL have parameter M_WIDTH, default 10: width of the window-length input.
REQ-003 SHALL have parameter WIN_DEPTH, default 16: maximum number of words in one window.
REQ-004 SHALL have port core_clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port r_enable, input, 1: GLB read strobe issued by the address mapper.
REQ-007 SHALL have port glb_rdata, input, DATA_WIDTH: GLB read data, valid one cycle after r_enable.
REQ-008 SHALL have port win_len, input, M_WIDTH: number of words per window.
REQ-009 SHALL have port full_flag, output, 1: window completely captured.
REQ-010 SHALL have port out_data, output, DATA_WIDTH: window word sent to the LRN datapath.
REQ-011 SHALL have port out_valid, output, 1: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: the datapath accepts out_data.
REQ-013 SHALL have port div_out_valid, input, 1: the divider has produced one normalized result.
REQ-014 SHALL have port normalized_window, output, 1: one-cycle pulse when the whole window is normalized.
REQ-015 SHALL have port fill_count, output, $clog2(WIN_DEPTH+1): number of words currently held.

Function
REQ-016 SHALL register r_enable one cycle internally as cap_en; each cycle cap_en=1 in FILL, write glb_rdata at wr_ptr, then wr_ptr+1 and fill_count+1.
REQ-017 SHALL latch win_len into eff_len on the first capture of a window; win_len=0 or win_len>WIN_DEPTH SHALL clamp eff_len to WIN_DEPTH.
REQ-018 SHALL implement FSM states FILL, DRAIN, WAIT_DIV and DONE; the reset state SHALL be FILL.
REQ-019 FILL->DRAIN SHALL occur in the cycle the capture makes fill_count equal eff_len; full_flag SHALL be registered and go high in that same transition cycle.
REQ-020 full_flag SHALL stay 1 in DRAIN and WAIT_DIV and SHALL be 0 in FILL and DONE.
REQ-021 In DRAIN, out_valid=1 and out_data=mem[rd_ptr]; a word SHALL be transferred only when out_valid and out_ready are both 1, after which rd_ptr+1.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 DRAIN->WAIT_DIV SHALL occur on the transfer of word eff_len-1; out_valid SHALL be 0 outside DRAIN.
REQ-024 SHALL count div_out_valid pulses in any state, saturating at eff_len.
REQ-025 WAIT_DIV->DONE SHALL occur when div_cnt reaches eff_len; a div_out_valid and a final transfer in the same cycle SHALL both be counted.
REQ-026 DONE SHALL assert normalized_window for exactly one cycle, clear all pointers and counters, and return to FILL the next cycle.
REQ-027 cap_en=1 outside FILL SHALL be ignored and SHALL NOT change the stored data or the pointers.
REQ-028 Pointers SHALL wrap to 0 at WIN_DEPTH-1.

Reset
REQ-029 Reset SHALL set state=FILL, full_flag=0, out_valid=0, out_data=0, normalized_window=0, fill_count=0, all pointers and counters=0, and cap_en=0.
REQ-030 Reset asserted mid-window SHALL discard that window; memory contents need not be cleared.

Configuration
REQ-031 When LRN_WB_OVERFLOW_CHK_EN is defined, SHALL add output overflow_err (1 bit), set sticky in the cycle after cap_en=1 outside FILL and cleared only by reset.
REQ-032 When LRN_WB_OVERFLOW_CHK_EN is not defined, the overflow_err port and its logic SHALL be absent.

Structure
REQ-033 The state enum lrn_wb_state_t SHALL live in shared package lrn_pkg, with the default WIN_DEPTH constant.
REQ-034 Storage SHALL be a sub-module lrn_wb_ram: a simple dual-port array with a synchronous write and a combinational read.

Verification
REQ-035 Fill: win_len=4, r_enable pulses with data 0x11..0x44 -> full_flag=1 one cycle after the 4th capture, fill_count=4.
REQ-036 Drain with backpressure: out_ready toggling 1,0,1,1,0,1 -> out_data sequence 0x11,0x22,0x33,0x44 with no loss or duplicate, and out_data held while stalled.
REQ-037 Completion: 4 div_out_valid pulses, the last one coinciding with the final transfer -> normalized_window=1 for one cycle, then FILL with fill_count=0.
REQ-038 Clamp: win_len=0 with WIN_DEPTH=16 -> full_flag asserts only after 16 captures; the pointers wrap cleanly on the next window.
REQ-039 Reset during DRAIN after 2 transfers -> all outputs 0 next cycle, and a new window fills correctly.
REQ-040 With LRN_WB_OVERFLOW_CHK_EN defined, r_enable during DRAIN -> overflow_err=1 two cycles later, data unchanged, flag stays set until reset.

Source files
------------

// File: rtl/lrn_pkg.sv
// lrn_pkg -- shared definitions for the LRN window buffer.
//   lrn_wb_state_t : window-buffer FSM state (FILL, DRAIN, WAIT_DIV, DONE)
//   LRN_WIN_DEPTH  : default maximum number of words in one window
//   lrn_clamp_len  : maps a requested window length to the length actually used
package lrn_pkg;

  localparam int LRN_WIN_DEPTH = 16;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_DIV = 2'd2,
    DONE     = 2'd3
  } lrn_wb_state_t;

  // A zero or oversized request means "use the whole buffer".
  function automatic int lrn_clamp_len(input int len, input int depth);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/lrn_wb_ram.sv
// lrn_wb_ram -- simple dual-port word store for one LRN window.
//   clk   : write clock (rising edge)
//   we    : write enable; wdata is stored at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data, mem[raddr]
// Contents are not reset.
module lrn_wb_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lrn_window_buffer.sv
// lrn_window_buffer -- captures one window of GLB words, streams it to the LRN
// datapath and waits until the divider has normalized every word.
//   core_clk          : clock (rising edge)
//   reset             : synchronous, active-high
//   r_enable          : GLB read strobe; glb_rdata is valid one cycle later
//   glb_rdata         : GLB read data
//   win_len           : words per window (0 or > WIN_DEPTH means WIN_DEPTH)
//   full_flag         : window captured and not yet finished (DRAIN/WAIT_DIV)
//   out_data/out_valid/out_ready : word stream to the datapath
//   div_out_valid     : one normalized result produced by the divider
//   normalized_window : one-cycle pulse when the whole window is normalized
//   fill_count        : words currently held
//   overflow_err      : only with LRN_WB_OVERFLOW_CHK_EN; sticky flag for a
//                       capture attempted outside FILL
//   state_dbg         : current FSM state
//
// Handshake: a word moves when out_valid && out_ready on a rising edge.
// out_valid never drops and out_data never changes while a word waits
// (out_valid=1, out_ready=0); out_valid does not depend on out_ready.
module lrn_window_buffer
  import lrn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int M_WIDTH    = 10,
  parameter int WIN_DEPTH  = LRN_WIN_DEPTH
) (
  input  logic                           core_clk,
  input  logic                           reset,
  input  logic                           r_enable,
  input  logic [DATA_WIDTH-1:0]          glb_rdata,
  input  logic [M_WIDTH-1:0]             win_len,
  output logic                           full_flag,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           div_out_valid,
  output logic                           normalized_window,
  output logic [$clog2(WIN_DEPTH+1)-1:0] fill_count,
`ifdef LRN_WB_OVERFLOW_CHK_EN
  output logic                           overflow_err,
`endif
  output lrn_wb_state_t                  state_dbg
);

  localparam int CW = $clog2(WIN_DEPTH + 1);
  localparam int AW = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;

  lrn_wb_state_t state, state_next;

  logic          cap_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill_cnt, div_cnt, eff_len;
  logic          full_q;

  logic          capture, first_cap, xfer, last_xfer, div_inc;
  logic [CW-1:0] len_first, len_now, fill_next;
  logic [DATA_WIDTH-1:0] ram_rdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(WIN_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // The length is taken from win_len on the first capture of a window and
  // held in eff_len after that, so the compare in that same cycle must use
  // the freshly clamped value.
  assign len_first = CW'(lrn_clamp_len(int'(win_len), WIN_DEPTH));
  assign capture   = cap_en && (state == FILL);
  assign first_cap = capture && (fill_cnt == '0);
  assign len_now   = first_cap ? len_first : eff_len;
  assign fill_next = fill_cnt + CW'(1);
  assign xfer      = (state == DRAIN) && out_ready;
  assign last_xfer = xfer && (CW'(rd_ptr) == eff_len - CW'(1));
  assign div_inc   = div_out_valid && (div_cnt < eff_len);

  always_ff @(posedge core_clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:     if (capture && (fill_next == len_now)) state_next = DRAIN;
      DRAIN:    if (last_xfer)                         state_next = WAIT_DIV;
      WAIT_DIV: if (div_cnt == eff_len)                state_next = DONE;
      DONE:                                            state_next = FILL;
      default:                                         state_next = FILL;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      cap_en   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      div_cnt  <= '0;
      eff_len  <= '0;
      full_q   <= 1'b0;
    end else begin
      cap_en <= r_enable;
      full_q <= (state_next == DRAIN) || (state_next == WAIT_DIV);
      if (state == DONE) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fill_cnt <= '0;
        div_cnt  <= '0;
      end else begin
        if (capture) begin
          wr_ptr   <= ptr_inc(wr_ptr);
          fill_cnt <= fill_next;
        end
        if (first_cap) eff_len <= len_first;
        if (xfer)      rd_ptr  <= ptr_inc(rd_ptr);
        if (div_inc)   div_cnt <= div_cnt + CW'(1);
      end
    end
  end

`ifdef LRN_WB_OVERFLOW_CHK_EN
  always_ff @(posedge core_clk) begin
    if (reset)                          overflow_err <= 1'b0;
    else if (cap_en && (state != FILL)) overflow_err <= 1'b1;
  end
`endif

  lrn_wb_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (WIN_DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (core_clk),
    .we   (capture),
    .waddr(wr_ptr),
    .wdata(glb_rdata),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  assign out_valid         = (state == DRAIN);
  assign out_data          = out_valid ? ram_rdata : '0;
  assign full_flag         = full_q;
  assign normalized_window = (state == DONE);
  assign fill_count        = fill_cnt;
  assign state_dbg         = state;

endmodule

// File: tb/tb_lrn_window_buffer.sv
// tb_lrn_window_buffer -- self-checking bench for lrn_window_buffer.
// Build with LRN_WB_OVERFLOW_CHK_EN defined to also exercise overflow_err.
module tb_lrn_window_buffer;
  import lrn_pkg::*;

  localparam int DW = 16;
  localparam int MW = 10;
  localparam int WD = 16;
  localparam int CW = $clog2(WD + 1);

  // ---------------- clock / reset ----------------
  logic core_clk = 1'b0;
  logic reset    = 1'b1;
  always #5 core_clk = ~core_clk;

  logic          r_enable = 1'b0;
  logic [DW-1:0] glb_rdata = '0;
  logic [MW-1:0] win_len = '0;
  logic          full_flag;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          div_out_valid = 1'b0;
  logic          normalized_window;
  logic [CW-1:0] fill_count;
  lrn_wb_state_t state_dbg;
`ifdef LRN_WB_OVERFLOW_CHK_EN
  logic          overflow_err;
`endif

  lrn_window_buffer #(.DATA_WIDTH(DW), .M_WIDTH(MW), .WIN_DEPTH(WD)) dut (
    .core_clk         (core_clk),
    .reset            (reset),
    .r_enable         (r_enable),
    .glb_rdata        (glb_rdata),
    .win_len          (win_len),
    .full_flag        (full_flag),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .div_out_valid    (div_out_valid),
    .normalized_window(normalized_window),
    .fill_count       (fill_count),
`ifdef LRN_WB_OVERFLOW_CHK_EN
    .overflow_err     (overflow_err),
`endif
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference rule for the window length actually used.
  function automatic int ref_len(input int w);
    return (w == 0 || w > WD) ? WD : w;
  endfunction

  task automatic tick();
    @(negedge core_clk);
  endtask

  // ---------------- driver tasks ----------------
  // Issues n GLB reads (the GLB answers one cycle after the strobe), records
  // every captured word in exp_q and checks fill_count/full_flag each cycle.
  task automatic run_fill(input int n, input int exp_len, input bit fixed);
    int      issued = 0;
    int      captured = 0;
    int      guard = 0;
    bit      pend = 0;
    bit      do_rd;
    logic [DW-1:0] pd = '0;
    while (captured < n) begin
      glb_rdata = pend ? pd : DW'($urandom);
      do_rd = (issued < n) && (fixed || ($urandom_range(0, 3) != 0));
      r_enable = do_rd;
      // win_len only matters on the first capture of a window
      if (captured > 0) win_len = MW'($urandom);
      tick();
      if (pend) begin
        captured++;
        exp_q.push_back(pd);
      end
      pend = do_rd;
      if (do_rd) begin
        issued++;
        pd = fixed ? DW'(issued * 'h11) : DW'($urandom);
      end
      check("fill_count", fill_count, captured);
      check("full_flag_fill", full_flag, captured == exp_len);
      check("out_valid_fill", out_valid, captured == exp_len);
      guard++;
      if (guard > 500) begin
        check("fill_timeout", 1, 0);
        break;
      end
    end
    r_enable = 1'b0;
  endtask

  // Drains exp_q with random backpressure, delivers len divider pulses and
  // checks the completion pulse. With coincide set, the last pulse during
  // the drain lands on the final transfer.
  task automatic run_drain_div(input int len, input bit coincide);
    int divs = 0;
    int guard = 0;
    bit rdy, dv;
    while (exp_q.size() > 0) begin
      check("out_valid_drain", out_valid, 1);
      check("out_data", out_data, exp_q[0]);
      check("full_flag_drain", full_flag, 1);
      rdy = ($urandom_range(0, 2) != 0);
      if (coincide && rdy && exp_q.size() == 1) dv = (divs < len);
      else if (coincide) dv = (divs < len - 1) && ($urandom_range(0, 1) == 1);
      else dv = (divs < len) && ($urandom_range(0, 2) == 0);
      out_ready = rdy;
      div_out_valid = dv;
      tick();
      if (rdy) void'(exp_q.pop_front());
      if (dv) divs++;
      guard++;
      if (guard > 1000) begin
        check("drain_timeout", 1, 0);
        exp_q.delete();
      end
    end
    out_ready = 1'b0;
    div_out_valid = 1'b0;
    guard = 0;
    while (divs < len) begin
      check("out_valid_wait", out_valid, 0);
      check("full_flag_wait", full_flag, 1);
      check("normalized_early", normalized_window, 0);
      dv = ($urandom_range(0, 1) == 1);
      div_out_valid = dv;
      tick();
      if (dv) divs++;
      guard++;
      if (guard > 1000) begin
        check("div_timeout", 1, 0);
        divs = len;
      end
    end
    div_out_valid = 1'b0;
    check("normalized_pre", normalized_window, 0);
    check("full_flag_pre", full_flag, 1);
    tick();
    check("normalized_pulse", normalized_window, 1);
    check("full_flag_done", full_flag, 0);
    check("out_valid_done", out_valid, 0);
    tick();
    check("normalized_end", normalized_window, 0);
    check("fill_count_end", fill_count, 0);
    check("state_end", state_dbg, FILL);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int win_len;
    int exp_len;
    bit coincide;
  } vec_t;

  vec_t vecs[7];

  logic [DW-1:0] hand_data[6];
  bit            hand_rdy[6];
  bit            hand_div[6];

  initial begin
    vecs[0] = '{win_len: 1,    exp_len: 1,  coincide: 1'b1};
    vecs[1] = '{win_len: 3,    exp_len: 3,  coincide: 1'b0};
    vecs[2] = '{win_len: 0,    exp_len: 16, coincide: 1'b1};
    vecs[3] = '{win_len: 7,    exp_len: 7,  coincide: 1'b0};
    vecs[4] = '{win_len: 17,   exp_len: 16, coincide: 1'b0};
    vecs[5] = '{win_len: 1023, exp_len: 16, coincide: 1'b1};
    vecs[6] = '{win_len: 16,   exp_len: 16, coincide: 1'b0};
    hand_data = '{16'h11, 16'h22, 16'h22, 16'h33, 16'h44, 16'h44};
    hand_rdy  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    hand_div  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset state
    repeat (3) tick();
    check("rst_full_flag", full_flag, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_normalized", normalized_window, 0);
    check("rst_fill_count", fill_count, 0);
    check("rst_state", state_dbg, FILL);
`ifdef LRN_WB_OVERFLOW_CHK_EN
    check("rst_overflow", overflow_err, 0);
`endif
    reset = 1'b0;
    tick();

    // fixed window 0x11..0x44, drain with backpressure, last divider pulse
    // on the final transfer
    win_len = MW'(4);
    run_fill(4, 4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("hand_out_valid", out_valid, 1);
      check("hand_out_data", out_data, hand_data[i]);
      out_ready = hand_rdy[i];
      div_out_valid = hand_div[i];
      tick();
    end
    out_ready = 1'b0;
    div_out_valid = 1'b0;
    exp_q.delete();
    check("hand_wait_valid", out_valid, 0);
    check("hand_wait_full", full_flag, 1);
    check("hand_wait_norm", normalized_window, 0);
    tick();
    check("hand_norm_pulse", normalized_window, 1);
    tick();
    check("hand_norm_end", normalized_window, 0);
    check("hand_fill_count", fill_count, 0);
    check("hand_state", state_dbg, FILL);

    // table-driven windows with random data and random handshakes
    for (int v = 0; v < 7; v++) begin
      win_len = MW'(vecs[v].win_len);
      check("ref_len", ref_len(vecs[v].win_len), vecs[v].exp_len);
      run_fill(vecs[v].exp_len, vecs[v].exp_len, 1'b0);
      run_drain_div(vecs[v].exp_len, vecs[v].coincide);
    end

    // reset during DRAIN after two transfers discards the window
    win_len = MW'(5);
    run_fill(5, 5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("rstmid_out_data", out_data, exp_q[0]);
      out_ready = 1'b1;
      tick();
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("rstmid_full_flag", full_flag, 0);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_data0", out_data, 0);
    check("rstmid_normalized", normalized_window, 0);
    check("rstmid_fill_count", fill_count, 0);
    check("rstmid_state", state_dbg, FILL);
    reset = 1'b0;
    win_len = MW'(3);
    run_fill(3, 3, 1'b0);
    run_drain_div(3, 1'b0);

    // a capture strobe during DRAIN must be ignored
    win_len = MW'(2);
    run_fill(2, 2, 1'b0);
    r_enable = 1'b1;
    glb_rdata = DW'($urandom);
    tick();
    r_enable = 1'b0;
    glb_rdata = 16'hdead;
`ifdef LRN_WB_OVERFLOW_CHK_EN
    check("ovf_not_yet", overflow_err, 0);
`endif
    tick();
`ifdef LRN_WB_OVERFLOW_CHK_EN
    check("ovf_set", overflow_err, 1);
`endif
    check("ignore_fill_count", fill_count, 2);
    check("ignore_out_data", out_data, exp_q[0]);
    run_drain_div(2, 1'b1);
`ifdef LRN_WB_OVERFLOW_CHK_EN
    check("ovf_sticky", overflow_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_cleared", overflow_err, 0);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
